// File: rtl/elastic_pipe_ctrl_pkg.sv
// Shared helpers for the elastic pipeline controller and its output skid FIFO.
package elastic_pipe_ctrl_pkg;

    // Bits needed to encode values 0 .. value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/out_skid_fifo.sv
// Two-entry output skid FIFO; its registered count is what the stage chain looks at,
// so downstream ready never reaches the upstream ready path.
module out_skid_fifo import elastic_pipe_ctrl_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_eff;
    logic             pop_eff;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign push_eff = push && (count != 2'd2);
    assign pop_eff  = pop  && (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (push_eff) wr_ptr <= ~wr_ptr;
            if (pop_eff)  rd_ptr <= ~rd_ptr;
            case ({push_eff, pop_eff})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are don't-care until count marks them valid.
    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/elastic_pipe_ctrl.sv
// Valid/ready elastic pipeline of DEPTH bubble-collapsing register stages feeding a
// 2-entry skid FIFO; stage enables are exported for lockstep side-band registers.
module elastic_pipe_ctrl import elastic_pipe_ctrl_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] stage_en,
    output logic [CNT_W-1:0] occupancy
);

    logic             v_q    [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] stage_en_w;
    logic [1:0]       fifo_cnt;
    logic             push_ok;
    logic             fifo_push;
    logic             fifo_pop;
    logic             accept;
    logic [CNT_W-1:0] occ_q;

    // Only the registered FIFO count gates the chain, never out_ready.
    assign push_ok = (fifo_cnt <= 2'd1);

    // A stage may load when it is empty or everything below it moves this cycle.
    always_comb begin
        logic en_acc;
        // NOTE: combinational logic uses blocking assignments with a default first, so no latch is inferred.
        en_acc     = push_ok;
        stage_en_w = '0;
        v          = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            v[i]          = v_q[i];
            en_acc        = en_acc | ~v_q[i];
            stage_en_w[i] = en_acc;
        end
    end

    assign stage_en = stage_en_w;
    assign in_ready = stage_en_w[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_next
            assign src_valid = v_q[i-1];
            assign src_data  = data_q[i-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[i] <= 1'b0;
            end else if (stage_en_w[i]) begin
                v_q[i] <= src_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (stage_en_w[i] && src_valid) data_q[i] <= src_data;
        end
    end

    assign fifo_push = v[DEPTH-1] && push_ok;
    assign fifo_pop  = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

    out_skid_fifo #(
        .WIDTH (WIDTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (data_q[DEPTH-1]),
        .pop       (fifo_pop),
        .head      (out_data),
        .count     (fifo_cnt)
    );

    assign out_valid = (fifo_cnt != 2'd0);

    // Tracking accepts minus pops keeps occ_q equal to popcount(v) + fifo_cnt every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + CNT_W'(accept) - CNT_W'(fifo_pop);
        end
    end

    assign occupancy = occ_q;

endmodule
